// File: rtl/xz_scrub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xz_scrub_pkg
// Description : Shared skid-buffer state type and mask popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package xz_scrub_pkg;

    localparam int POP_W = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    function automatic logic [POP_W-1:0] popcount(input logic [63:0] mask);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + POP_W'(mask[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xz_scrub_lane.sv
`default_nettype none
// ============================================================================
// Module      : xz_scrub_lane
// Description : Replaces X/Z bits of one channel with FILL; reports mask and
//               number of replaced bits.
// Revision    : 1.0 - initial release
// ============================================================================
module xz_scrub_lane
    import xz_scrub_pkg::*;
#(
    parameter int   W    = 8,
    parameter logic FILL = 1'b0
) (
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     out_data,
    output logic [W-1:0]     out_xmask,
    output logic [POP_W-1:0] out_pop
);

    // A bit is clean only when it is a definite 0 or 1.
    always_comb begin
        out_data  = '0;
        out_xmask = '0;
        for (int i = 0; i < W; i++) begin
            if ((in_data[i] === 1'b0) || (in_data[i] === 1'b1)) begin
                out_data[i]  = in_data[i];
                out_xmask[i] = 1'b0;
            end else begin
                out_data[i]  = FILL;
                out_xmask[i] = 1'b1;
            end
        end
    end

    assign out_pop = popcount(64'(out_xmask));

endmodule
`default_nettype wire

// File: rtl/xz_scrub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : xz_scrub_pipe
// Description : Multi-channel X/Z scrubber behind a 2-entry skid buffer with
//               optional per-channel X/Z event counters (XZ_SCRUB_PIPE_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module xz_scrub_pipe
    import xz_scrub_pkg::*;
#(
    parameter int   NCH   = 4,
    parameter int   W     = 8,
    parameter logic FILL  = 1'b0,
    parameter int   CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NCH-1:0][W-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output bit   [NCH-1:0][W-1:0]     out_data,
    output bit   [NCH-1:0][W-1:0]     out_xmask,
    input  logic                      clr_cnt
`ifdef XZ_SCRUB_PIPE_STATS_EN
    ,
    output bit   [NCH-1:0][CNT_W-1:0] xz_cnt
`endif
);

    logic [NCH-1:0][W-1:0]     w_data;
    logic [NCH-1:0][W-1:0]     w_mask;
    logic [NCH-1:0][POP_W-1:0] w_pop;
    logic                      w_accept;
    logic                      w_drain;

    state_t                state_q,     state_d;
    logic [NCH-1:0][W-1:0] head_data_q, head_data_d;
    logic [NCH-1:0][W-1:0] head_mask_q, head_mask_d;
    logic [NCH-1:0][W-1:0] tail_data_q, tail_data_d;
    logic [NCH-1:0][W-1:0] tail_mask_q, tail_mask_d;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        xz_scrub_lane #(
            .W    (W),
            .FILL (FILL)
        ) u_lane (
            .in_data   (in_data[c]),
            .out_data  (w_data[c]),
            .out_xmask (w_mask[c]),
            .out_pop   (w_pop[c])
        );
    end

    assign in_ready  = (state_q != TWO) && !rst;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_data_q;
    assign out_xmask = head_mask_q;
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    // Head always feeds the output; tail only fills while the head is stalled.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_mask_d = head_mask_q;
        tail_data_d = tail_data_q;
        tail_mask_d = tail_mask_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    head_data_d = w_data;
                    head_mask_d = w_mask;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    head_data_d = w_data;
                    head_mask_d = w_mask;
                end else if (w_accept) begin
                    tail_data_d = w_data;
                    tail_mask_d = w_mask;
                    state_d     = TWO;
                end else if (w_drain) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (w_drain) begin
                    head_data_d = tail_data_q;
                    head_mask_d = tail_mask_q;
                    state_d     = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_mask_q <= '0;
            tail_data_q <= '0;
            tail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_mask_q <= head_mask_d;
            tail_data_q <= tail_data_d;
            tail_mask_q <= tail_mask_d;
        end
    end

`ifdef XZ_SCRUB_PIPE_STATS_EN
    localparam int               SUM_W     = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] c_cnt_max = SUM_W'({CNT_W{1'b1}});

    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]          w_sum;

    // A clear coincident with an accept restarts from that beat's count.
    always_comb begin
        cnt_d = cnt_q;
        w_sum = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sum = (clr_cnt ? SUM_W'(0) : SUM_W'(cnt_q[c]))
                  + (w_accept ? SUM_W'(w_pop[c]) : SUM_W'(0));
            cnt_d[c] = (w_sum > c_cnt_max) ? CNT_W'(c_cnt_max) : CNT_W'(w_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xz_cnt = cnt_q;
`else
    logic unused_stats;
    assign unused_stats = clr_cnt ^ (^w_pop);
`endif

endmodule
`default_nettype wire

// File: tb/tb_xz_scrub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_xz_scrub_pipe
// Description : Scoreboard bench for xz_scrub_pipe (counters checked when
//               XZ_SCRUB_PIPE_STATS_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xz_scrub_pipe;

    localparam int   NCH   = 4;
    localparam int   W     = 8;
    localparam logic FILL  = 1'b0;
    localparam int   CNT_W = 4;
    localparam int   CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [NCH*W-1:0] d;
        logic [NCH*W-1:0] m;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [NCH-1:0][W-1:0] in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    bit   [NCH-1:0][W-1:0] out_data;
    bit   [NCH-1:0][W-1:0] out_xmask;
    logic                  clr_cnt = 1'b0;
`ifdef XZ_SCRUB_PIPE_STATS_EN
    bit   [NCH-1:0][CNT_W-1:0] xz_cnt;
`endif

    int    errors = 0;
    int    checks = 0;
    beat_t sb[$];
    int    cnt_m[NCH];
    bit    prev_rst = 1'b1;
    bit    hold_v = 1'b0;
    logic [63:0] hold_val = '0;

    always #5 clk = ~clk;

    xz_scrub_pipe #(
        .NCH   (NCH),
        .W     (W),
        .FILL  (FILL),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_xmask (out_xmask),
        .clr_cnt   (clr_cnt)
`ifdef XZ_SCRUB_PIPE_STATS_EN
        ,
        .xz_cnt    (xz_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: any bit that is not a definite 0/1 becomes FILL and is flagged.
    function automatic beat_t model(input logic [NCH-1:0][W-1:0] d);
        beat_t b;
        logic [NCH-1:0][W-1:0] od, om;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($isunknown(d[c][i])) begin
                    od[c][i] = FILL;
                    om[c][i] = 1'b1;
                end else begin
                    od[c][i] = d[c][i];
                    om[c][i] = 1'b0;
                end
            end
        end
        b.d = od;
        b.m = om;
        return b;
    endfunction

    function automatic logic [NCH-1:0][W-1:0] rand_beat();
        logic [NCH-1:0][W-1:0] v;
        if ($urandom_range(0, 19) == 0) begin
            v = {(NCH*W){1'bx}};
        end else begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < W; i++) begin
                    if ($urandom_range(0, 9) == 0) v[c][i] = 1'bx;
                    else v[c][i] = 1'($urandom_range(0, 1));
                end
            end
        end
        return v;
    endfunction

    // One cycle of stimulus; checks flow-control and counters against the model.
    task automatic drive(input bit v, input logic [NCH-1:0][W-1:0] d, input bit ordy,
                         input bit clr, input bit r, output bit acc);
        beat_t b;
        int    pc;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr_cnt   = clr;
        rst       = r;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!r && (sb.size() < 2)));
        chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        if (prev_rst) begin
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_xmask", 64'(out_xmask), 64'd0);
        end
`ifdef XZ_SCRUB_PIPE_STATS_EN
        for (int c = 0; c < NCH; c++) chk("xz_cnt", 64'(xz_cnt[c]), 64'(cnt_m[c]));
`endif
        acc = v && in_ready;
        if (r) begin
            sb.delete();
            for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
        end else begin
            b = model(d);
            if (acc) sb.push_back(b);
            for (int c = 0; c < NCH; c++) begin
                pc = acc ? $countones(b.m[c*W +: W]) : 0;
                if (clr) cnt_m[c] = pc;
                else cnt_m[c] = (cnt_m[c] + pc > CMAX) ? CMAX : cnt_m[c] + pc;
            end
        end
        prev_rst = r;
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (hold_v && !rst) chk("hold_stable", {out_xmask, out_data}, hold_val);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_xmask", 64'(out_xmask), 64'(e.m));
                end
            end
            hold_v   = !rst && out_valid && !out_ready;
            hold_val = {out_xmask, out_data};
        end
    end

    initial begin : stim
        logic [NCH-1:0][W-1:0] d;
        bit acc;
        int n;
        for (int c = 0; c < NCH; c++) cnt_m[c] = 0;

        drive(1'b1, '0, 1'b1, 1'b0, 1'b1, acc);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);

        // Mixed-bit beat on ch0 with the sink ready.
        d = '0;
        d[0] = 8'b1x0x_0011;
        drive(1'b1, d, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Sink stalled: two beats fill the skid, the third waits.
        for (int k = 0; k < 3; k++) begin
            d = rand_beat();
            drive(1'b1, d, 1'b0, 1'b0, 1'b0, acc);
            if (k == 2) chk("third_beat_blocked", 64'(acc), 64'd0);
        end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            drive(1'b1, d, 1'b1, 1'b0, 1'b0, acc);
            n++;
        end
        chk("third_beat_accepted", 64'(acc), 64'd1);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // All-X beats on ch1 drive its counter into saturation.
        d = '0;
        d[1] = {W{1'bx}};
        repeat (16) drive(1'b1, d, 1'b1, 1'b0, 1'b0, acc);

        // Clear coincident with an accept of three X bits on ch2.
        d = '0;
        d[2] = 8'b0x1x_0x00;
        drive(1'b1, d, 1'b1, 1'b1, 1'b0, acc);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        for (int k = 0; k < 1500; k++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_beat(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                  1'b0, acc);
        end

        // Reset while the skid is full, then a normal accept.
        repeat (3) drive(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, acc);
        drive(1'b1, rand_beat(), 1'b1, 1'b0, 1'b1, acc);
        drive(1'b1, rand_beat(), 1'b1, 1'b0, 1'b0, acc);
        chk("accept_after_rst", 64'(acc), 64'd1);

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            n++;
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        chk("drain_timeout", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xz_scrub_pipe.md
XZ_SCRUB_PIPE -- requirements
Module: xz_scrub_pipe

Interface
REQ-001 The block SHALL have parameter NCH, default 4, number of independent channels (1..16).
REQ-002 The block SHALL have parameter W, default 8, bits per channel (1..64).
REQ-003 The block SHALL have parameter FILL, default 1'b0, the 2-state value substituted for any X or Z input bit.
REQ-004 The block SHALL have parameter CNT_W, default 16, the width of each per-channel X/Z event counter.
REQ-005 The block SHALL have port clk, input, 1, the sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1, upstream beat present.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a beat.
REQ-009 The block SHALL have port in_data, input, logic [NCH-1:0][W-1:0], 4-state payload.
REQ-010 The block SHALL have port out_valid, output, 1, scrubbed beat present.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-012 The block SHALL have port out_data, output, bit [NCH-1:0][W-1:0], 2-state scrubbed payload.
REQ-013 The block SHALL have port out_xmask, output, bit [NCH-1:0][W-1:0], 1 where the source bit was X or Z.
REQ-014 The block SHALL have port clr_cnt, input, 1, synchronous clear of all counters.
REQ-015 The block SHALL have port xz_cnt, output, bit [NCH-1:0][CNT_W-1:0], per-channel X/Z bit count (present only per REQ-030).

Function
REQ-016 A beat SHALL transfer in on in_valid && in_ready and out on out_valid && out_ready at a clk edge.
REQ-017 Each in_data bit that is 0 or 1 SHALL pass unchanged; each X or Z bit SHALL become FILL with its out_xmask bit set.
REQ-018 Scrubbing SHALL be combinational at the input; the scrubbed beat and mask SHALL appear at the output one cycle after acceptance (latency 1).
REQ-019 Buffering SHALL be a 2-entry skid: state machine EMPTY, ONE, TWO.
REQ-020 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; TWO->ONE on drain; ONE stays ONE on simultaneous accept and drain.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO and while rst is high.
REQ-022 out_valid SHALL be 1 in ONE and TWO; out_data/out_xmask SHALL hold stable while out_valid && !out_ready.
REQ-023 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-024 On each accept, xz_cnt[c] SHALL increase by the popcount of channel c's X/Z mask, saturating at 2**CNT_W-1.
REQ-025 clr_cnt SHALL zero all counters; clr_cnt coincident with an accept SHALL load the counters with that beat's popcounts.
REQ-026 An all-Z beat SHALL count W per channel and output FILL replicated.

Reset
REQ-027 With rst high at a clk edge: state EMPTY, out_valid 0, out_data 0, out_xmask 0, xz_cnt 0.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered beats; no beat accepted in that cycle.
REQ-029 First accept SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-030 Macro XZ_SCRUB_PIPE_STATS_EN: defined -> counters, clr_cnt and xz_cnt exist per REQ-024/025; undefined -> no counter logic, xz_cnt port omitted, clr_cnt ignored; datapath behaviour identical.

Structure
REQ-031 Package xz_scrub_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and a function returning popcount of a mask.
REQ-032 Sub-module xz_scrub_lane SHALL scrub one W-bit channel (data, mask, popcount) and be instantiated NCH times.

Verification
REQ-033 Defaults, in_data ch0=8'b1x0z_0011, out_ready=1 -> next cycle out_data ch0=8'b1000_0011, out_xmask ch0=8'b0101_0000, xz_cnt[0]=2.
REQ-034 out_ready=0, three in_valid beats -> two accepted, in_ready=0 in TWO; release out_ready -> both emerge in order, then third accepted.
REQ-035 CNT_W=4, sixteen all-X beats on ch1 -> xz_cnt[1]=15 saturated after second beat (8+8>15), never wraps.
REQ-036 clr_cnt with accept of beat holding 3 X on ch2 -> xz_cnt[2]=3 next cycle, other channels 0.
REQ-037 rst pulsed while in TWO -> out_valid=0, counters 0, next edge in_ready=1 and beat accepted normally.
REQ-038 Build without XZ_SCRUB_PIPE_STATS_EN, repeat REQ-033 -> identical out_data/out_xmask, no xz_cnt port.
